// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered and change only in the commit cycle.
module sequential_divider #(
  parameter int unsigned Word_Length = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [Word_Length-1:0] dividend,
  input  logic [Word_Length-1:0] divisor,
  output logic [Word_Length-1:0] quotient,
  output logic [Word_Length-1:0] remainder,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero
);

  localparam int unsigned WL = Word_Length;
  localparam int unsigned CW = $clog2(WL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WL-1:0]   rw_q, rw_d;
  logic [WL-1:0]   qw_q, qw_d;
  logic [WL-1:0]   dw_q, dw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WL-1:0]   quot_q, quot_d;
  logic [WL-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Partial remainder is kept WL bits wide: after each step it is below the
  // divisor, so only the shifted value needs the extra bit.
  logic [WL:0]     r_sh;
  logic [WL:0]     trial;
  logic [WL-1:0]   r_next;
  logic [WL-1:0]   q_next;

  always_comb begin
    r_sh   = {rw_q, qw_q[WL-1]};
    trial  = r_sh - {1'b0, dw_q};
    r_next = trial[WL] ? r_sh[WL-1:0] : trial[WL-1:0];
    q_next = {qw_q[WL-2:0], ~trial[WL]};
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    qw_d    = qw_q;
    dw_d    = dw_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            qw_d    = dividend;
            dw_d    = divisor;
            rw_d    = '0;
            cnt_d   = CW'(WL);
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        rw_d  = r_next;
        qw_d  = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quot_d  = q_next;
          rem_d   = r_next;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rw_q    <= '0;
      qw_q    <= '0;
      dw_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      qw_q    <= qw_d;
      dw_q    <= dw_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and random checks of sequential_divider (Word_Length=8) using
// immediate assertions; inputs change 1ns after rising edges.
module tb_sequential_divider;

  localparam int unsigned WL = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [WL-1:0] dividend;
  logic [WL-1:0] divisor;
  logic [WL-1:0] quotient;
  logic [WL-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int n_checks;
  int n_fail;
  int cyc;
  int busy_cnt;
  int hold_bad;
  logic [WL-1:0] hold_q;
  logic [WL-1:0] hold_r;

  sequential_divider #(.Word_Length(WL)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair for a single accepting edge.
  task automatic launch(input logic [WL-1:0] n, input logic [WL-1:0] d);
    hold_q   = quotient;
    hold_r   = remainder;
    hold_bad = 0;
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    tick();
    start    = 1'b0;
    cyc      = 0;
    busy_cnt = 0;
  endtask

  task automatic step();
    if (busy === 1'b1) busy_cnt++;
    if (quotient !== hold_q || remainder !== hold_r) hold_bad++;
    tick();
    cyc++;
  endtask

  task automatic finish_op(input string tag, input logic [WL-1:0] eq, input logic [WL-1:0] er,
                           input logic edbz, input int elat);
    while (done !== 1'b1 && cyc < 40) step();
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " busy cycles"}, busy_cnt, elat);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, edbz);
    chk({tag, " held"}, hold_bad, 0);
    tick();
    chk({tag, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [WL-1:0] n;
    logic [WL-1:0] d;
    int seen_done;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    reset = 1'b1;
    tick();

    launch(8'd100, 8'd7);  finish_op("100/7", 8'd14, 8'd2, 1'b0, 8);
    launch(8'd255, 8'd1);  finish_op("255/1", 8'd255, 8'd0, 1'b0, 8);
    launch(8'd5, 8'd9);    finish_op("5/9", 8'd0, 8'd5, 1'b0, 8);
    launch(8'd0, 8'd3);    finish_op("0/3", 8'd0, 8'd0, 1'b0, 8);
    launch(8'd42, 8'd0);   finish_op("42/0", 8'hFF, 8'd42, 1'b1, 0);

    // Second start during CALC must be ignored.
    launch(8'd200, 8'd13);
    step();
    step();
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    step();
    start = 1'b0;
    finish_op("200/13 ignore", 8'd15, 8'd5, 1'b0, 8);

    // Reset mid-operation: outputs clear immediately, no result afterwards.
    launch(8'd100, 8'd7);
    step(); step(); step();
    reset = 1'b0;
    #2;
    chk("midreset quotient", quotient, 0);
    chk("midreset remainder", remainder, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset dbz", div_by_zero, 0);
    tick();
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    chk("midreset no done", seen_done, 0);
    launch(8'd50, 8'd5);   finish_op("50/5", 8'd10, 8'd0, 1'b0, 8);

    // Back-to-back: second start in the IDLE cycle right after done.
    launch(8'd100, 8'd7);  finish_op("b2b first", 8'd14, 8'd2, 1'b0, 8);
    launch(8'd77, 8'd8);   finish_op("b2b second", 8'd9, 8'd5, 1'b0, 8);

    for (int i = 0; i < 1000; i++) begin
      n = WL'($urandom);
      d = ($urandom_range(0, 7) == 0) ? '0 : WL'($urandom);
      launch(n, d);
      if (d == 0) finish_op("rand dbz", 8'hFF, n, 1'b1, 0);
      else        finish_op("rand", n / d, n % d, 1'b0, 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
